// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 initiator, one {rw,addr,data} frame per request.
// Read-back of cipo into rsp_rdata is enabled by defining SPI_RD_EN.
module spi_reg_writer #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              ncs,
  output logic              copi,
  input  logic              cipo
);
  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FW);

  localparam logic [CW-1:0] RELOAD    = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FW - 1);
  localparam logic [BW-1:0] DATA_BITS = BW'(DATA_W);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [FW-1:0] shreg;
  logic [FW-1:0] frame;
  logic          rw_bit;
  logic          accept;
  logic          cnt_done;
  logic          hold_done;

  assign accept    = req_valid && req_ready;
  assign cnt_done  = (cnt == '0);
  assign hold_done = (state == HOLD) && cnt_done;
  assign frame     = {rw_bit, req_addr, req_wdata};

`ifdef SPI_RD_EN
  logic              frame_rw;
  logic [DATA_W-1:0] rx;
  logic              sample;

  assign rw_bit = req_rw;
  // cipo is taken at the end of each high phase of the data bits
  assign sample = (state == SHIFT) && sclk && cnt_done
                  && (bit_cnt < DATA_BITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_rw  <= 1'b0;
      rx        <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept)
        frame_rw <= req_rw;
      if (sample)
        rx <= (rx << 1) | DATA_W'(cipo);
      if (hold_done && !frame_rw)
        rsp_rdata <= rx;
    end
  end
`else
  logic unused_in;

  assign unused_in = ^{cipo, req_rw};
  assign rw_bit    = 1'b1;
  assign rsp_rdata = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ncs       <= 1'b1;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= SETUP;
            cnt       <= RELOAD;
            bit_cnt   <= LAST_BIT;
            shreg     <= frame;
            copi      <= frame[FW-1];
            ncs       <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_done) begin
            state <= SHIFT;
            sclk  <= 1'b1;
            cnt   <= RELOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (!cnt_done) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt  <= RELOAD;
            sclk <= !sclk;
            // falling edge: advance copi, or hand the low half to HOLD
            if (sclk) begin
              if (bit_cnt == '0) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
                shreg   <= shreg << 1;
                copi    <= shreg[FW-2];
              end
            end
          end
        end
        HOLD: begin
          if (cnt_done) begin
            state     <= GAP;
            cnt       <= RELOAD;
            ncs       <= 1'b1;
            copi      <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt_done) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ncs       <= 1'b1;
          sclk      <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_writer.sv
// tb_spi_reg_writer: randomized bench for spi_reg_writer with a
// line-level monitor/peripheral model and per-scenario checking tasks.
module tb_spi_reg_writer;
  localparam int CLK_DIV   = 4;
  localparam int FRAME_LOW = 33 * CLK_DIV;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       sclk;
  logic       ncs;
  logic       copi;
  logic       cipo;

  int checks = 0;
  int errors = 0;

  spi_reg_writer #(.CLK_DIV(CLK_DIV), .ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // line monitor and peripheral model, sampled on the falling clk edge
  logic [15:0] frames[$];
  int          lows[$];
  int          gaps[$];
  logic [7:0]  rdq[$];
  logic [15:0] shift_in;
  logic [7:0]  rd_val;
  logic [7:0]  exp_rdata;
  int          low_cnt, high_cnt, nbits;
  int          rsp_cnt, rsp_bad, copi_glitch;
  logic        prev_ncs, prev_sclk, prev_copi;

  initial begin
    cipo = 1'b0; rd_val = 8'h00; shift_in = '0;
    low_cnt = 0; high_cnt = 0; nbits = 0;
    rsp_cnt = 0; rsp_bad = 0; copi_glitch = 0;
    prev_ncs = 1'b1; prev_sclk = 1'b0; prev_copi = 1'b0;
    forever begin
      @(negedge clk);
      if (!ncs) begin
        if (prev_ncs) begin
          gaps.push_back(high_cnt);
          low_cnt = 0; nbits = 0; shift_in = '0;
        end
        low_cnt++;
        if (sclk && !prev_sclk) begin
          shift_in = {shift_in[14:0], copi};
          nbits++;
        end
        if (sclk && prev_sclk && copi !== prev_copi)
          copi_glitch++;
        if (!sclk)
          cipo = (nbits >= 8 && nbits <= 15) ? rd_val[15-nbits] : 1'b0;
      end else begin
        if (!prev_ncs) begin
          frames.push_back(shift_in);
          lows.push_back(low_cnt);
          high_cnt = 0;
        end
        high_cnt++;
        cipo = 1'b0;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rdq.push_back(rsp_rdata);
        if (!(ncs && !prev_ncs)) rsp_bad++;
      end
      prev_ncs = ncs; prev_sclk = sclk; prev_copi = copi;
    end
  end

  function automatic logic [15:0] exp_frame(input logic rw,
      input logic [6:0] a, input logic [7:0] d);
`ifdef SPI_RD_EN
    return {rw, a, d};
`else
    return {1'b1, a, d};
`endif
  endfunction

  task automatic model_rsp(input logic rw);
`ifdef SPI_RD_EN
    if (!rw) exp_rdata = rd_val;
`else
    exp_rdata = 8'h00;
`endif
  endtask

  task automatic clear_mon();
    frames.delete(); lows.delete(); gaps.delete(); rdq.delete();
    copi_glitch = 0; rsp_bad = 0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready);
    end
  endtask

  task automatic wait_rsp(input string name, input int target);
    int n = 0;
    while (rsp_cnt < target && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (rsp_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s rsp_timeout: rsp_count=%0d required %0d", name, rsp_cnt, target);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic scramble();
    req_rw = 1'($urandom); req_addr = 7'($urandom); req_wdata = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; scramble();
    #23;
    checks++;
    if ({ncs, sclk, copi, req_ready, busy, rsp_valid} !== 6'b100100) begin
      errors++;
      $display("FAIL reset outputs: ncs/sclk/copi/rdy/busy/rsp=%b required 100100",
               {ncs, sclk, copi, req_ready, busy, rsp_valid});
    end
    checks++;
    if (rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset rdata: got %h required 00", rsp_rdata);
    end
    exp_rdata = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write(input string name, input logic rw,
      input logic [6:0] a, input logic [7:0] d);
    logic [15:0] ef;
    int base;
    ef = exp_frame(rw, a, d);
    wait_ready(name);
    clear_mon();
    base = rsp_cnt;
    rd_val = 8'($urandom);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; scramble();
    checks++;
    if ({busy, ncs, req_ready, copi} !== {3'b100, ef[15]}) begin
      errors++;
      $display("FAIL %s accept: busy/ncs/rdy/copi=%b required %b",
               name, {busy, ncs, req_ready, copi}, {3'b100, ef[15]});
    end
    wait_rsp(name, base + 1);
    model_rsp(rw);
    checks++;
    if (frames.size() != 1 || frames[0] !== ef) begin
      errors++;
      $display("FAIL %s frame: got %h (n=%0d) required %h", name,
               frames.size() > 0 ? frames[0] : 16'hxxxx, frames.size(), ef);
    end
    checks++;
    if (lows.size() != 1 || lows[0] != FRAME_LOW) begin
      errors++;
      $display("FAIL %s ncs_low: got %0d required %0d", name,
               lows.size() > 0 ? lows[0] : -1, FRAME_LOW);
    end
    checks++;
    if (rsp_cnt - base != 1 || rsp_bad != 0) begin
      errors++;
      $display("FAIL %s rsp_pulse: got %0d pulses (%0d misaligned) required 1",
               name, rsp_cnt - base, rsp_bad);
    end
    checks++;
    if (rdq.size() != 1 || rdq[0] !== exp_rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h required %h", name,
               rdq.size() > 0 ? rdq[0] : 8'hxx, exp_rdata);
    end
    checks++;
    if (copi_glitch != 0) begin
      errors++;
      $display("FAIL %s copi_stable: got %0d changes in high phase required 0",
               name, copi_glitch);
    end
  endtask

  task automatic test_back_to_back();
    int base, n;
    logic [15:0] e0, e1;
    e0 = exp_frame(1'b1, 7'h02, 8'hFF);
    e1 = exp_frame(1'b1, 7'h04, 8'h80);
    wait_ready("b2b");
    clear_mon();
    base = rsp_cnt;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h02; req_wdata = 8'hFF;
    @(posedge clk); #1;
    req_addr = 7'h04; req_wdata = 8'h80;
    n = 0;
    while (!req_ready && n < 1000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0; scramble();
    wait_rsp("b2b", base + 2);
    checks++;
    if (frames.size() != 2 || frames[0] !== e0 || frames[1] !== e1) begin
      errors++;
      $display("FAIL b2b frames: got %0d frames %h %h required %h %h",
               frames.size(), frames.size() > 0 ? frames[0] : 16'hxxxx,
               frames.size() > 1 ? frames[1] : 16'hxxxx, e0, e1);
    end
    checks++;
    if (gaps.size() != 2 || gaps[1] < CLK_DIV + 1) begin
      errors++;
      $display("FAIL b2b gap: got %0d cycles required >= %0d",
               gaps.size() > 1 ? gaps[1] : -1, CLK_DIV + 1);
    end
    checks++;
    if (rsp_cnt - base != 2) begin
      errors++;
      $display("FAIL b2b rsp_count: got %0d required 2", rsp_cnt - base);
    end
  endtask

  task automatic test_ignored();
    int base;
    logic [15:0] ef;
    ef = exp_frame(1'b1, 7'h11, 8'h5A);
    wait_ready("ignored");
    clear_mon();
    base = rsp_cnt;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h11; req_wdata = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    req_valid = 1'b1; scramble();
    repeat (3) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    wait_rsp("ignored", base + 1);
    repeat (3 * CLK_DIV + 10) begin @(posedge clk); #1; end
    checks++;
    if (frames.size() != 1 || frames[0] !== ef || rsp_cnt - base != 1) begin
      errors++;
      $display("FAIL ignored frames: got %0d frames %0d rsp required 1 frame %h",
               frames.size(), rsp_cnt - base, ef);
    end
  endtask

  task automatic test_reset_mid();
    int base, n;
    wait_ready("rst_mid");
    clear_mon();
    base = rsp_cnt;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h33; req_wdata = 8'hC3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (nbits < 10 && n < 1000) begin @(posedge clk); #1; n++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ncs, sclk, busy, req_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL rst_mid async: ncs/sclk/busy/rdy=%b required 1001",
               {ncs, sclk, busy, req_ready});
    end
    exp_rdata = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (150) begin @(posedge clk); #1; end
    checks++;
    if (rsp_cnt != base || ncs !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid no_rsp: got %0d pulses ncs=%b required 0 and 1",
               rsp_cnt - base, ncs);
    end
    test_write("rst_mid_after", 1'b1, 7'h05, 8'h69);
  endtask

  task automatic test_random(input int count);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      test_write($sformatf("rand%0d", i), 1'($urandom),
                 7'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write("t1_write", 1'b1, 7'h00, 8'hF0);
    test_back_to_back();
    test_ignored();
    test_write("t4_read", 1'b0, 7'h03, 8'h00);
    test_write("t5_rw0", 1'b0, 7'h01, 8'h3C);
    test_reset_mid();
    test_random(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
